ofmap_accum_drain: RTL and testbench
====================================

// Module: ofmap_accum_drain
// PURPOSE
//  Output stage downstream of the conv datapath. Accepts one deskewed row of systolic-array
//  partial sums per handshake (ARRAY_WIDTH output channels of one output pixel), accumulates
//  them over a configured number of passes (IC1*FY*FX) in a local accumulation buffer, then
//  drains the finished OX0*OY0 x OC0 tile word-by-word onto the 32-bit ofmap stream.
// PARAMETERS
//  OFMAP_WIDTH     32  bits per partial sum / output word
//  ARRAY_WIDTH     4   output channels per psum row (OC0)
//  ACC_DEPTH       9   output pixels per tile (OX0*OY0); >= 1
//  PASS_WIDTH      16  width of pass-count config
// PORTS
//  clk          in   1                        clock, rising edge
//  rst_n        in   1                        reset, synchronous, active-low
//  cfg_en       in   1                        latch cfg_passes (honoured in IDLE only)
//  cfg_passes   in   PASS_WIDTH               accumulation passes per tile; 0 treated as 1
//  psum_dat     in   OFMAP_WIDTH*ARRAY_WIDTH  psum row; channel c at [c*OFMAP_WIDTH +: OFMAP_WIDTH]
//  psum_vld     in   1                        psum_dat valid
//  psum_rdy     out  1                        block accepts a psum row this cycle
//  ofmap_dat    out  OFMAP_WIDTH              output word
//  ofmap_vld    out  1                        ofmap_dat valid
//  ofmap_rdy    in   1                        consumer accepts ofmap_dat
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, pix_ptr=0, pass_cnt=0, drain_ptr=0, psum_rdy=0,
//   ofmap_vld=0, ofmap_dat=0, passes reg=1. Accumulation buffer contents need not be cleared.
//  Handshake: transfer iff vld&rdy at posedge. ofmap_vld, once high, stays high with ofmap_dat
//   stable until accepted. psum_rdy is a registered output, independent of psum_vld.
//  IDLE: psum_rdy=0. cfg_en=1 -> latch max(cfg_passes,1), go ACCUM next cycle.
//  ACCUM: psum_rdy=1. Per accepted row at pix_ptr: pass_cnt==0 -> buf[pix_ptr]=psum_dat
//   (overwrite); else buf[pix_ptr]+=psum_dat per channel. Same-cycle read-modify-write, result
//   visible to next access. pix_ptr wraps ACC_DEPTH-1 -> 0 and increments pass_cnt.
//   Row accepted with pix_ptr==ACC_DEPTH-1 and pass_cnt==passes-1 -> DRAIN next cycle,
//   psum_rdy=0 in that next cycle, pass_cnt=0, pix_ptr=0. cfg_en ignored.
//  DRAIN: psum_rdy=0 (psum_vld ignored, no buffer change). Words emitted pixel-major,
//   channel 0 first: word k = buf[k/ARRAY_WIDTH] channel k%ARRAY_WIDTH, k=0..ACC_DEPTH*ARRAY_WIDTH-1.
//   ofmap_vld=1 on first DRAIN cycle (1 cycle after final psum accept). Each accepted word
//   advances drain_ptr; next word presented the following cycle (zero bubbles under
//   continuous ofmap_rdy). After last word accepted: ofmap_vld=0, drain_ptr=0, return to
//   ACCUM (psum_rdy=1) next cycle with same passes value; cfg_en still ignored.
//  Arithmetic: two's-complement add, modulo 2^OFMAP_WIDTH; no saturation, no overflow flag.
//  Reset mid-operation: any state -> IDLE as above; partially accumulated/drained tile dropped,
//   new cfg_en required before psum_rdy rises again.
//  ACC_DEPTH=1, passes=1: every accepted row drains immediately (ARRAY_WIDTH words).
// TESTING
//  T1 passes=1: cfg_en; 9 rows, row p ch c = 4p+c, ofmap_rdy=1 -> ofmap 0..35 in order on 36
//     consecutive cycles, ofmap_vld first high 1 cycle after 9th accept, psum_rdy low throughout.
//  T2 passes=3: 27 rows, all channels = 5 -> 36 words of 15; second tile of rows=1 yields 3
//     (buffer overwritten on pass 0, no carry-over).
//  T3 backpressure: ofmap_rdy random 50% during T1 drain -> same 36 values, ofmap_dat never
//     changes while vld&!rdy, no word dropped or duplicated.
//  T4 wrap: passes=2, pixel 0 ch0 0xFFFFFFFF then 0x00000002 -> first word 0x00000001;
//     0x80000000+0x80000000 -> 0x00000000.
//  T5 reset: assert rst_n=0 after 10 of 36 words drained -> next cycle ofmap_vld=0, psum_rdy=0;
//     psum_vld held high stays unaccepted until cfg_en; fresh T1 tile then drains correctly.
//  T6 cfg_passes=0 behaves as 1; cfg_en pulsed during ACCUM/DRAIN has no effect on pass count.

Source files
------------

// File: rtl/ofmap_accum_drain.sv
// Output accumulation and drain stage for the conv datapath.
// Sums psum rows over a configured pass count, then streams the tile out word by word.
module ofmap_accum_drain #(
    parameter int OFMAP_WIDTH = 32,
    parameter int ARRAY_WIDTH = 4,
    parameter int ACC_DEPTH   = 9,
    parameter int PASS_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_en,
    input  logic [PASS_WIDTH-1:0]              cfg_passes,
    input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] psum_dat,
    input  logic                               psum_vld,
    output logic                               psum_rdy,
    output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
    output logic                               ofmap_vld,
    input  logic                               ofmap_rdy
);

    localparam int ROW_W = OFMAP_WIDTH * ARRAY_WIDTH;
    localparam int PIX_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
    localparam int CH_W  = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(ACC_DEPTH - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(ARRAY_WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PIX_W-1:0]      pix_ptr_q, pix_ptr_d;
    logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [PASS_WIDTH-1:0] passes_q, passes_d;
    logic [PIX_W-1:0]      drain_pix_q, drain_pix_d;
    logic [CH_W-1:0]       drain_ch_q, drain_ch_d;
    logic                  psum_rdy_q, psum_rdy_d;
    logic                  ofmap_vld_q, ofmap_vld_d;

    logic [ROW_W-1:0]      acc_q [ACC_DEPTH];

    logic                  psum_fire;
    logic                  ofmap_fire;
    logic                  last_pix;
    logic                  last_pass;
    logic [ROW_W-1:0]      acc_rd;
    logic [ROW_W-1:0]      wr_row;
    logic [ROW_W-1:0]      drain_row;
    logic [OFMAP_WIDTH-1:0] drain_word;

    // psum_rdy_q is only ever high in ACCUM, so it alone qualifies a row transfer
    assign psum_fire  = psum_vld & psum_rdy_q;
    assign ofmap_fire = ofmap_vld_q & ofmap_rdy;
    assign last_pix   = (pix_ptr_q == PIX_LAST);
    assign last_pass  = (pass_cnt_q == passes_q - PASS_WIDTH'(1));

    assign acc_rd    = acc_q[pix_ptr_q];
    assign drain_row = acc_q[drain_pix_q];

    assign psum_rdy  = psum_rdy_q;
    assign ofmap_vld = ofmap_vld_q;
    assign ofmap_dat = ofmap_vld_q ? drain_word : '0;

    // Per-channel read-modify-write value; pass 0 overwrites stale tile data
    always_comb begin
        wr_row = '0;
        for (int c = 0; c < ARRAY_WIDTH; c++) begin
            if (pass_cnt_q == '0) begin
                wr_row[c*OFMAP_WIDTH +: OFMAP_WIDTH] =
                    psum_dat[c*OFMAP_WIDTH +: OFMAP_WIDTH];
            end else begin
                wr_row[c*OFMAP_WIDTH +: OFMAP_WIDTH] =
                    acc_rd[c*OFMAP_WIDTH +: OFMAP_WIDTH] +
                    psum_dat[c*OFMAP_WIDTH +: OFMAP_WIDTH];
            end
        end
    end

    // Channel select of the pixel currently being drained
    always_comb begin
        drain_word = '0;
        for (int c = 0; c < ARRAY_WIDTH; c++) begin
            if (drain_ch_q == CH_W'(c)) begin
                drain_word = drain_row[c*OFMAP_WIDTH +: OFMAP_WIDTH];
            end
        end
    end

    // Control FSM: pointer, pass counter and handshake next-state logic
    always_comb begin
        state_d     = state_q;
        pix_ptr_d   = pix_ptr_q;
        pass_cnt_d  = pass_cnt_q;
        passes_d    = passes_q;
        drain_pix_d = drain_pix_q;
        drain_ch_d  = drain_ch_q;
        ofmap_vld_d = ofmap_vld_q;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_en) begin
                    // a zero pass count would never complete a tile
                    if (cfg_passes == '0) begin
                        passes_d = PASS_WIDTH'(1);
                    end else begin
                        passes_d = cfg_passes;
                    end
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (psum_fire) begin
                    if (last_pix) begin
                        pix_ptr_d = '0;
                        if (last_pass) begin
                            pass_cnt_d  = '0;
                            state_d     = S_DRAIN;
                            ofmap_vld_d = 1'b1;
                        end else begin
                            pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
                        end
                    end else begin
                        pix_ptr_d = pix_ptr_q + PIX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (ofmap_fire) begin
                    if (drain_ch_q == CH_LAST) begin
                        drain_ch_d = '0;
                        if (drain_pix_q == PIX_LAST) begin
                            drain_pix_d = '0;
                            ofmap_vld_d = 1'b0;
                            state_d     = S_ACCUM;
                        end else begin
                            drain_pix_d = drain_pix_q + PIX_W'(1);
                        end
                    end else begin
                        drain_ch_d = drain_ch_q + CH_W'(1);
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                ofmap_vld_d = 1'b0;
            end
        endcase

        psum_rdy_d = (state_d == S_ACCUM);
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pix_ptr_q   <= '0;
            pass_cnt_q  <= '0;
            passes_q    <= PASS_WIDTH'(1);
            drain_pix_q <= '0;
            drain_ch_q  <= '0;
            psum_rdy_q  <= 1'b0;
            ofmap_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_ptr_q   <= pix_ptr_d;
            pass_cnt_q  <= pass_cnt_d;
            passes_q    <= passes_d;
            drain_pix_q <= drain_pix_d;
            drain_ch_q  <= drain_ch_d;
            psum_rdy_q  <= psum_rdy_d;
            ofmap_vld_q <= ofmap_vld_d;
        end
    end

    // Accumulation buffer; contents are don't-care until pass 0 writes them
    always_ff @(posedge clk) begin
        if (rst_n && psum_fire) begin
            acc_q[pix_ptr_q] <= wr_row;
        end
    end

endmodule

// File: tb/tb_ofmap_accum_drain.sv
// Randomized scoreboard bench for ofmap_accum_drain.
// Expected tile words come from a pass-sum model over the issued rows.
module tb_ofmap_accum_drain;

    localparam int OW = 32;
    localparam int W  = 4;
    localparam int D  = 9;
    localparam int NW = W * D;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_en = 1'b0;
    logic [15:0]     cfg_passes = '0;
    logic [OW*W-1:0] psum_dat = '0;
    logic            psum_vld = 1'b0;
    logic            psum_rdy;
    logic [OW-1:0]   ofmap_dat;
    logic            ofmap_vld;
    logic            ofmap_rdy = 1'b1;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    bit rdy_rand = 1'b0;

    logic [OW-1:0]   exp_q[$];
    logic [OW*W-1:0] rows[$];

    ofmap_accum_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .cfg_passes (cfg_passes),
        .psum_dat   (psum_dat),
        .psum_vld   (psum_vld),
        .psum_rdy   (psum_rdy),
        .ofmap_dat  (ofmap_dat),
        .ofmap_vld  (ofmap_vld),
        .ofmap_rdy  (ofmap_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // consumer ready: constant high or random 50%
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ofmap_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: pops expected words on each transfer, checks hold stability
    initial begin
        bit            hold_pend;
        logic [OW-1:0] hold_dat;
        hold_pend = 1'b0;
        hold_dat  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hold_pend) begin
                    chk("hold_vld", 32'(ofmap_vld), 32'd1);
                    chk("hold_dat", ofmap_dat, hold_dat);
                end
                if (ofmap_vld) chk("psum_rdy_in_drain", 32'(psum_rdy), 32'd0);
                if (ofmap_vld && ofmap_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", ofmap_dat, 32'hxxxxxxxx);
                    end else begin
                        chk("word", ofmap_dat, exp_q.pop_front());
                    end
                    n_out++;
                end
                hold_pend = ofmap_vld && !ofmap_rdy;
                hold_dat  = ofmap_dat;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        psum_vld = 1'b0;
        cfg_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_psum_rdy", 32'(psum_rdy), 32'd0);
        chk("rst_ofmap_vld", 32'(ofmap_vld), 32'd0);
        chk("rst_ofmap_dat", ofmap_dat, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic configure(input logic [15:0] p);
        cfg_en = 1'b1;
        cfg_passes = p;
        @(posedge clk);
        #1;
        cfg_en = 1'b0;
    endtask

    task automatic send_row(input logic [OW*W-1:0] r);
        int n;
        psum_dat = r;
        psum_vld = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!psum_rdy && n < 1000);
        if (!psum_rdy) chk("psum_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        psum_vld = 1'b0;
    endtask

    // reference: word k = sum over passes of row(pass, k/W) channel k%W
    task automatic issue_tile(input int np);
        logic [OW-1:0]   s;
        logic [OW*W-1:0] r;
        for (int k = 0; k < NW; k++) begin
            s = '0;
            for (int p = 0; p < np; p++) begin
                r = rows[p*D + k/W];
                s = s + r[(k%W)*OW +: OW];
            end
            exp_q.push_back(s);
        end
        for (int i = 0; i < rows.size(); i++) send_row(rows[i]);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !ofmap_vld && psum_rdy) && n < 3000);
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        chk("drain_idle_vld", 32'(ofmap_vld), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rows_t1();
        logic [OW*W-1:0] r;
        rows.delete();
        for (int p = 0; p < D; p++) begin
            for (int c = 0; c < W; c++) r[c*OW +: OW] = 32'(4*p + c);
            rows.push_back(r);
        end
    endtask

    task automatic rows_const(input int np, input logic [OW-1:0] v);
        rows.delete();
        for (int i = 0; i < np*D; i++) rows.push_back({W{v}});
    endtask

    task automatic rows_rand(input int np);
        logic [OW*W-1:0] r;
        rows.delete();
        for (int i = 0; i < np*D; i++) begin
            for (int c = 0; c < W; c++) r[c*OW +: OW] = $urandom;
            rows.push_back(r);
        end
    endtask

    initial begin
        int target;
        logic [OW*W-1:0] r;

        do_reset();

        // T1: passes=1 ramp, exact timing with continuous ready
        configure(16'd1);
        rows_t1();
        issue_tile(1);
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            chk("t1_vld_streak", 32'(ofmap_vld), 32'd1);
        end
        @(negedge clk);
        chk("t1_vld_after", 32'(ofmap_vld), 32'd0);
        chk("t1_rdy_after", 32'(psum_rdy), 32'd1);
        @(posedge clk);
        #1;
        chk("t1_left", 32'(exp_q.size()), 32'd0);

        // T6a: cfg_en asserted during ACCUM and DRAIN must not change passes
        cfg_en = 1'b1;
        cfg_passes = 16'd3;
        rows_rand(1);
        issue_tile(1);
        wait_drained();
        cfg_en = 1'b0;

        // T3: random backpressure on the T1 ramp
        rdy_rand = 1'b1;
        rows_t1();
        issue_tile(1);
        wait_drained();
        rdy_rand = 1'b0;

        // T2: passes=3 constant rows, then overwrite check with ones
        do_reset();
        configure(16'd3);
        rows_const(3, 32'd5);
        issue_tile(3);
        wait_drained();
        rows_const(3, 32'd1);
        issue_tile(3);
        wait_drained();

        // T4: modular wrap on pixel 0
        do_reset();
        configure(16'd2);
        rows_rand(2);
        r = rows[0];
        r[0 +: OW]  = 32'hFFFFFFFF;
        r[OW +: OW] = 32'h80000000;
        rows[0] = r;
        r = rows[D];
        r[0 +: OW]  = 32'h00000002;
        r[OW +: OW] = 32'h80000000;
        rows[D] = r;
        issue_tile(2);
        @(negedge clk);
        chk("t4_word0", ofmap_dat, 32'h00000001);
        @(negedge clk);
        chk("t4_word1", ofmap_dat, 32'h00000000);
        wait_drained();

        // T6b: cfg_passes=0 behaves as 1
        do_reset();
        configure(16'd0);
        rows_rand(1);
        issue_tile(1);
        wait_drained();

        // T5: reset after 10 words of a drain
        do_reset();
        configure(16'd1);
        rows_t1();
        target = n_out + 10;
        issue_tile(1);
        for (int n = 0; n < 500 && n_out < target; n++) @(posedge clk);
        chk("t5_reached10", 32'(n_out >= target), 32'd1);
        #1;
        rst_n = 1'b0;
        psum_vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_vld", 32'(ofmap_vld), 32'd0);
        chk("t5_rdy", 32'(psum_rdy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_accept", 32'(psum_rdy), 32'd0);
        end
        @(posedge clk);
        #1;
        psum_vld = 1'b0;
        configure(16'd1);
        rows_t1();
        issue_tile(1);
        wait_drained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
